// File: rtl/tone_sequencer_if.sv
// Control and status bundle of the tone sequencer: mode/select inputs in,
// registered divider count and note status out.
interface tone_sequencer_if;
    logic        enable;
    logic        auto_mode;
    logic [2:0]  sw_sel;
    logic [31:0] count_end;
    logic [2:0]  note_idx;
    logic        tone_on;
    logic        update;

    modport master (
        output enable, auto_mode, sw_sel,
        input  count_end, note_idx, tone_on, update
    );

    modport slave (
        input  enable, auto_mode, sw_sel,
        output count_end, note_idx, tone_on, update
    );
endinterface

// File: rtl/tone_sequencer.sv
// Tone sequencer: selects a half-period count from an 8-note scale, manually or
// by stepping automatically. Define TONE_SEQ_GAP_EN to insert silent gaps between auto notes.
module tone_sequencer #(
    parameter int unsigned DWELL_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES   = 2_500_000
) (
    input  logic           clock_in,
    input  logic           reset,
    tone_sequencer_if.slave bus
);

`ifdef TONE_SEQ_GAP_EN
    typedef enum logic [1:0] {IDLE, MANUAL, AUTO, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, MANUAL, AUTO} state_t;
`endif

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
`ifdef TONE_SEQ_GAP_EN
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
`endif

    function automatic logic [31:0] note_count(input logic [2:0] idx);
        case (idx)
            3'd0:    note_count = 32'd47801;
            3'd1:    note_count = 32'd42589;
            3'd2:    note_count = 32'd37936;
            3'd3:    note_count = 32'd35816;
            3'd4:    note_count = 32'd31928;
            3'd5:    note_count = 32'd28409;
            3'd6:    note_count = 32'd25329;
            default: note_count = 32'd23900;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  note_q, note_d;
    logic [31:0] dwell_q, dwell_d;
    logic [31:0] count_q, count_d;
    logic        tone_q;
    logic        update_q;
`ifdef TONE_SEQ_GAP_EN
    logic [31:0] gap_q, gap_d;
`endif

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        dwell_d = dwell_q;
`ifdef TONE_SEQ_GAP_EN
        gap_d   = gap_q;
`endif
        if (!bus.enable) begin
            state_d = IDLE;
            dwell_d = '0;
`ifdef TONE_SEQ_GAP_EN
            gap_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE, MANUAL: begin
                    if (bus.auto_mode) begin
                        state_d = AUTO;
                        note_d  = 3'd0;
                        dwell_d = '0;
                    end else begin
                        state_d = MANUAL;
                        note_d  = bus.sw_sel;
                    end
                end
                AUTO: begin
                    if (!bus.auto_mode) begin
                        state_d = MANUAL;
                        note_d  = bus.sw_sel;
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
`ifdef TONE_SEQ_GAP_EN
                        state_d = GAP;
                        gap_d   = '0;
`else
                        note_d  = note_q + 3'd1;
`endif
                    end else begin
                        dwell_d = dwell_q + 32'd1;
                    end
                end
`ifdef TONE_SEQ_GAP_EN
                GAP: begin
                    // note_idx keeps the last note through the gap and advances on exit.
                    if (!bus.auto_mode) begin
                        state_d = MANUAL;
                        note_d  = bus.sw_sel;
                        gap_d   = '0;
                    end else if (gap_q == GAP_LAST) begin
                        state_d = AUTO;
                        note_d  = note_q + 3'd1;
                        dwell_d = '0;
                        gap_d   = '0;
                    end else begin
                        gap_d   = gap_q + 32'd1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        // Outputs are derived from the next state so they change on the same edge.
        count_d = ((state_d == MANUAL) || (state_d == AUTO)) ? note_count(note_d) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q  <= IDLE;
            note_q   <= 3'd0;
            dwell_q  <= '0;
            count_q  <= '0;
            tone_q   <= 1'b0;
            update_q <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            dwell_q  <= dwell_d;
            count_q  <= count_d;
            tone_q   <= (count_d != '0);
            update_q <= (count_d != count_q);
`ifdef TONE_SEQ_GAP_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign bus.count_end = count_q;
    assign bus.note_idx  = note_q;
    assign bus.tone_on   = tone_q;
    assign bus.update    = update_q;

endmodule
